// File: rtl/mips_data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache of one-word lines in front of a fixed-latency backing store.
// Read hit completes in the same cycle, a read miss takes LATENCY+1 cycles and a write takes LATENCY cycles; the core holds its request until ready.
module mips_data_cache #(
  parameter int MEM_WORDS = 1024,
  parameter int LINES     = 8,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  input  logic            mem_read_en,
  output logic [0:3][7:0] mem_data_out,
  output logic            ready
);

  localparam int WB = $clog2(MEM_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = WB - IB;
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [31:0]      backing   [MEM_WORDS];
  logic [31:0]      line_data [LINES];
  logic [TB-1:0]    line_tag  [LINES];
  logic [LINES-1:0] line_vld;

  logic [WB-1:0] word;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;
  logic          hit;
  logic          cnt_done;
  logic          fill_done;
  logic          write_done;
  logic          unused_addr_bits;

  // Byte offset and bits above the backing store are dropped, so addresses alias modulo the store size.
  assign word             = mem_addr[WB+1:2];
  assign index            = word[IB-1:0];
  assign tag              = word[WB-1:IB];
  assign unused_addr_bits = ^{mem_addr[31:WB+2], mem_addr[1:0]};

  assign hit        = line_vld[index] && (line_tag[index] == tag);
  assign cnt_done   = (cnt == '0);
  assign fill_done  = (state == FILL) && cnt_done;
  assign write_done = (state == WRITE) && cnt_done;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_write_en) begin
          state_nxt = WRITE;
          cnt_nxt   = CNT_LOAD;
        end else if (mem_read_en && !hit) begin
          state_nxt = FILL;
          cnt_nxt   = CNT_LOAD;
        end
      end
      FILL, WRITE: begin
        if (cnt_done) state_nxt = IDLE;
        else          cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready        = 1'b0;
    mem_data_out = '0;
    case (state)
      IDLE: begin
        if (mem_read_en && !mem_write_en && hit) begin
          ready        = 1'b1;
          mem_data_out = line_data[index];
        end
      end
      WRITE:   ready = cnt_done;
      default: ready = 1'b0;
    endcase
  end

  // Reset aborts an in-flight write: the backing word is only touched on a non-reset edge.
  always_ff @(posedge clk) begin
    if (rst_b && write_done) backing[word] <= mem_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst_b && (fill_done || (write_done && hit))) begin
      line_data[index] <= fill_done ? backing[word] : mem_data_in;
    end
    if (rst_b && fill_done) line_tag[index] <= tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_b)         line_vld        <= '0;
    else if (fill_done) line_vld[index] <= 1'b1;
  end

endmodule

// File: tb/tb_mips_data_cache.sv
// Bench for mips_data_cache: directed vector table, reset corner sequences, then random traffic against a word-level model.
module tb_mips_data_cache;

  localparam int MEM_WORDS = 1024;
  localparam int LINES     = 8;
  localparam int LATENCY   = 4;
  localparam int BUDGET    = 40;

  logic            clk;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic            mem_read_en;
  logic [0:3][7:0] mem_data_out;
  logic            ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [MEM_WORDS];
  bit          m_vld [LINES];
  int          m_tag [LINES];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_lat;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs [11];

  mips_data_cache #(
    .MEM_WORDS(MEM_WORDS),
    .LINES    (LINES),
    .LATENCY  (LATENCY)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_read_en (mem_read_en),
    .mem_data_out(mem_data_out),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; holds the request until ready, then releases it after the completing edge.
  task automatic run_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] q, output int busy_out);
    mem_addr     = a;
    mem_data_in  = d;
    mem_write_en = wr;
    mem_read_en  = rd;
    lat      = -1;
    q        = '0;
    busy_out = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = c;
        q   = mem_data_out;
        break;
      end
      if (mem_data_out !== 32'h0) busy_out++;
    end
    @(posedge clk);
    #1;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
  endtask

  task automatic req_check(input string name, input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input int exp_lat, input logic [31:0] exp_q);
    int          lat;
    logic [31:0] q;
    int          busy_out;
    run_req(wr, rd, a, d, lat, q, busy_out);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_data"}, q, exp_q);
    check({name, "_quiet"}, 32'(busy_out), 32'h0);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check({name, "_rdy"}, 32'(ready), 32'h0);
    check({name, "_out"}, mem_data_out, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b        = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle_check("reset");

    // Preload backing words through the write path, then reset to start cold.
    req_check("pre40", 1, 0, 32'h40, 32'hDEADBEEF, LATENCY, 32'h0);
    req_check("pre60", 1, 0, 32'h60, 32'h60606060, LATENCY, 32'h0);
    req_check("pre80", 1, 0, 32'h80, 32'h80808080, LATENCY, 32'h0);
    do_reset();
    idle_check("cold");

    vecs[0]  = '{0, 1, 32'h0000_0040, 32'h0,        LATENCY + 1, 32'hDEADBEEF};
    vecs[1]  = '{0, 1, 32'h0000_0040, 32'h0,        0,           32'hDEADBEEF};
    vecs[2]  = '{1, 0, 32'h0000_0040, 32'h11223344, LATENCY,     32'h0};
    vecs[3]  = '{0, 1, 32'h0000_0040, 32'h0,        0,           32'h11223344};
    vecs[4]  = '{0, 1, 32'h0000_0060, 32'h0,        LATENCY + 1, 32'h60606060};
    vecs[5]  = '{0, 1, 32'h0000_0040, 32'h0,        LATENCY + 1, 32'h11223344};
    vecs[6]  = '{1, 1, 32'h0000_0044, 32'hCAFEF00D, LATENCY,     32'h0};
    vecs[7]  = '{0, 1, 32'h0000_0044, 32'h0,        LATENCY + 1, 32'hCAFEF00D};
    vecs[8]  = '{1, 0, 32'h0000_1004, 32'hA5A5A5A5, LATENCY,     32'h0};
    vecs[9]  = '{0, 1, 32'h0000_0004, 32'h0,        LATENCY + 1, 32'hA5A5A5A5};
    vecs[10] = '{0, 1, 32'h0000_1007, 32'h0,        0,           32'hA5A5A5A5};

    for (int i = 0; i < 11; i++) begin
      req_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
                vecs[i].exp_lat, vecs[i].exp_q);
    end
    idle_check("after_vec");

    // Reset two cycles into a read miss: fill aborted, re-issued read misses again.
    mem_addr    = 32'h80;
    mem_read_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("midfill_c%0d_rdy", c), 32'(ready), 32'h0);
      @(posedge clk);
      #1;
    end
    rst_b       = 1'b0;
    mem_read_en = 1'b0;
    @(negedge clk);
    check("midfill_rst_rdy", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle_check("midfill_post");
    req_check("midfill_reread", 0, 1, 32'h80, 32'h0, LATENCY + 1, 32'h80808080);
    req_check("midfill_hit", 0, 1, 32'h80, 32'h0, 0, 32'h80808080);

    // Reset two cycles into a write: backing word keeps its old value.
    mem_addr     = 32'h40;
    mem_data_in  = 32'h0BADBAD0;
    mem_write_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("midwr_c%0d_rdy", c), 32'(ready), 32'h0);
      @(posedge clk);
      #1;
    end
    rst_b        = 1'b0;
    mem_write_en = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle_check("midwr_post");
    req_check("midwr_reread", 0, 1, 32'h40, 32'h0, LATENCY + 1, 32'h11223344);

    // Random traffic over 32 words with aliasing upper bits, checked against a word-level model.
    do_reset();
    for (int l = 0; l < LINES; l++) m_vld[l] = 1'b0;
    for (int w = 0; w < 32; w++) begin
      int          lat;
      logic [31:0] q;
      int          busy_out;
      logic [31:0] d;
      d = $urandom;
      m_mem[w] = d;
      run_req(1, 0, 32'(w * 4), d, lat, q, busy_out);
      if (lat != LATENCY) begin
        errors++;
        $display("FAIL init_w%0d: latency %0d expected %0d", w, lat, LATENCY);
      end
      checks++;
    end
    for (int i = 0; i < 300; i++) begin
      int          w;
      int          idx;
      int          tg;
      int          sel;
      bit          wr;
      bit          rd;
      logic [31:0] a;
      logic [31:0] d;
      int          exp_lat;
      logic [31:0] exp_q;
      w   = $urandom_range(0, 31);
      a   = ($urandom_range(0, 15) << 12) | 32'(w << 2) | $urandom_range(0, 3);
      d   = $urandom;
      sel = $urandom_range(0, 9);
      wr  = (sel <= 4);
      rd  = (sel >= 4);
      w   = int'((a >> 2) % MEM_WORDS);
      idx = w % LINES;
      tg  = w / LINES;
      if (wr) begin
        exp_lat  = LATENCY;
        exp_q    = 32'h0;
        m_mem[w] = d;
      end else begin
        exp_lat    = (m_vld[idx] && m_tag[idx] == tg) ? 0 : LATENCY + 1;
        exp_q      = m_mem[w];
        m_vld[idx] = 1'b1;
        m_tag[idx] = tg;
      end
      req_check($sformatf("rnd%0d", i), wr, rd, a, d, exp_lat, exp_q);
      if ($urandom_range(0, 7) == 0) idle_check($sformatf("rnd%0d_gap", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_data_cache.md
MIPS_DATA_CACHE -- requirements
Module: mips_data_cache

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: backing-store size in 32-bit words, power of two.
REQ-002 SHALL have parameter LINES, default 8: number of direct-mapped one-word cache lines, power of two.
REQ-003 SHALL have parameter LATENCY, default 4, legal range 1 or more: backing-store access time in cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_b, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port mem_addr, input, 32 bits: byte address from the core's ALU result.
REQ-007 SHALL have port mem_data_in, input, 4 x 8 bits ([7:0] [0:3]): write data, big-endian, byte 0 = bits 31:24.
REQ-008 SHALL have port mem_write_en, input, 1 bit: write request.
REQ-009 SHALL have port mem_read_en, input, 1 bit: read request.
REQ-010 SHALL have port mem_data_out, output, 4 x 8 bits ([7:0] [0:3]): read data, big-endian, byte 0 = bits 31:24.
REQ-011 SHALL have port ready, output, 1 bit: the current request completes this cycle.

Function
REQ-012 Address decode SHALL be: word = mem_addr[log2(MEM_WORDS)+1:2]; index = low log2(LINES) bits of word; tag = remaining word bits.
- mem_addr[1:0] ignored; upper address bits ignored, so addresses wrap modulo 4*MEM_WORDS.
REQ-013 FSM SHALL have three states: IDLE, FILL, WRITE. A down-counter SHALL be log2(LATENCY)+1 bits wide.
REQ-014 Request priority in IDLE SHALL be: mem_write_en wins over mem_read_en.
REQ-015 In IDLE, a read that hits (line valid, tag equal) SHALL assert ready combinationally in the same cycle and drive the line data; FSM stays in IDLE.
REQ-016 In IDLE, a read miss SHALL hold ready=0, load counter=LATENCY-1 and enter FILL.
REQ-017 In FILL, the counter SHALL decrement each cycle.
- At the edge where counter==0: line data = backing word, tag stored, valid set, FSM returns to IDLE.
- The next cycle is a hit. Miss penalty: ready rises LATENCY+1 cycles after the request is first presented.
REQ-018 In IDLE, a write SHALL hold ready=0, load counter=LATENCY-1 and enter WRITE.
REQ-019 In WRITE, ready SHALL be 1 only in the cycle where counter==0. At that edge:
- backing word = mem_data_in;
- if the line is valid with a matching tag, line data is updated as well (write-through, no write-allocate);
- FSM returns to IDLE.
REQ-020 The core SHALL hold mem_addr, data and enables stable from request until ready; the block samples them every cycle and does not latch them.
REQ-021 Write or read enables still asserted in the IDLE cycle after completion SHALL be treated as a new request.
REQ-022 mem_data_out SHALL be 32'h0 in every cycle except a read-hit ready cycle.
REQ-023 With no enable asserted in IDLE, outputs SHALL be ready=0 and mem_data_out=0, and no state changes.
REQ-024 A read that misses on an index holding a different tag SHALL evict that line on fill completion.

Reset
REQ-025 With rst_b=0 at a clock edge, the block SHALL set FSM=IDLE, counter=0 and clear all valid bits; outputs become ready=0 and mem_data_out=0.
REQ-026 Backing-store contents SHALL NOT be altered by reset.
REQ-027 Reset during FILL SHALL abort the fill, with no line written.
REQ-028 Reset during WRITE SHALL abort the write, with the backing word and line unchanged.

Verification (LATENCY=4, LINES=8, MEM_WORDS=1024)
REQ-029 Cold read miss: preload word[0x10]=32'hDEADBEEF, reset, then hold read at 0x40 from cycle 0 -> ready=0 for cycles 0-4; cycle 5 ready=1 with mem_data_out={DE,AD,BE,EF}.
REQ-030 Hit and write: repeat read 0x40 -> ready=1 in the same cycle. Then write 32'h11223344 to 0x40 -> ready=0 for cycles 0-3, ready=1 at cycle 4. Then read 0x40 -> immediate hit returning {11,22,33,44}.
REQ-031 Conflict: read 0x60 (same index 0, different tag) -> miss with ready at cycle 5, line evicted; then read 0x40 -> miss again with ready at cycle 5 and data unchanged.
REQ-032 Reset mid-fill: start read miss at 0x80, pulse rst_b=0 at cycle 2 -> ready stays 0 and nothing is filled; re-issued read misses with ready 5 cycles later.
REQ-033 Simultaneous enables: assert mem_read_en and mem_write_en together at 0x44 with data 32'hCAFEF00D -> write path taken (ready at cycle 4, mem_data_out=0); a following read returns {CA,FE,F0,0D} after the miss fill.
REQ-034 Address wrap: write 32'hA5A5A5A5 to 0x1004 -> word[1] is updated, and a read of 0x0004 returns {A5,A5,A5,A5}.
